// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-low segment encodings {g,f,e,d,c,b,a},
// active-low anode selects, and small helpers used by the scan display.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Decimal digit encodings, common-anode (a 0 lights the segment)
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Active-low anode selects; AN_Dk enables digit k
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    // Anode pattern for a given digit index
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = AN_D0;
            2'd1:    an = AN_D1;
            2'd2:    an = AN_D2;
            default: an = AN_D3;
        endcase
        return an;
    endfunction

    // True when any nibble of a packed 4-digit word is not a decimal digit
    function automatic logic bcd_has_invalid(input logic [15:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd[k*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to common-anode 7-segment decoder.
// Non-decimal nibbles render as a dash so bad data is visible on the panel.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Table lookup with dash fallback for 10..15
    always_comb begin
        o_seg = SEG_DASH;
        case (i_nib)
            4'd0: o_seg = SEG_DIGIT[0];
            4'd1: o_seg = SEG_DIGIT[1];
            4'd2: o_seg = SEG_DIGIT[2];
            4'd3: o_seg = SEG_DIGIT[3];
            4'd4: o_seg = SEG_DIGIT[4];
            4'd5: o_seg = SEG_DIGIT[5];
            4'd6: o_seg = SEG_DIGIT[6];
            4'd7: o_seg = SEG_DIGIT[7];
            4'd8: o_seg = SEG_DIGIT[8];
            4'd9: o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 4-digit common-anode display driver. Captures a packed
// BCD word on the converter's ready strobe into a shadow register and scans
// d3..d0 with a dark dead time at the start of each slot to avoid ghosting.
module bcd_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        bcd_valid,
    input  logic [15:0] bcd_in,
    input  logic        blank_en,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        bcd_err
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] r_presc;
    logic [1:0]       r_idx;
    logic [15:0]      r_shadow;
    logic             r_err;
    logic [3:0]       r_anode;
    logic [6:0]       r_seg;

    logic [3:0]       w_nib;
    logic [6:0]       w_dec;
    logic             w_dead;
    logic [3:0]       w_zero;
    logic             w_blank;
    logic [3:0]       w_anode_nxt;
    logic [6:0]       w_seg_nxt;

    // Slot prescaler and digit index; the wrap cycle steps the index downward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 2'd3;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= r_idx - 2'd1;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
        end
    end

    // Capture every strobe; error flag tracks the most recently captured word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= 16'h0000;
            r_err    <= 1'b0;
        end else if (bcd_valid) begin
            r_shadow <= bcd_in;
            r_err    <= bcd_has_invalid(bcd_in);
        end
    end

    // Select the nibble for the current digit index
    always_comb begin
        w_nib = r_shadow[15:12];
        case (r_idx)
            2'd0:    w_nib = r_shadow[3:0];
            2'd1:    w_nib = r_shadow[7:4];
            2'd2:    w_nib = r_shadow[11:8];
            default: w_nib = r_shadow[15:12];
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // Leading-zero blanking: digit k blanks only if it and all higher digits are 0
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_zero[k] = (r_shadow[k*4 +: 4] == 4'd0);
        end
        w_blank = 1'b0;
        case (r_idx)
            2'd3:    w_blank = blank_en & w_zero[3];
            2'd2:    w_blank = blank_en & w_zero[3] & w_zero[2];
            2'd1:    w_blank = blank_en & w_zero[3] & w_zero[2] & w_zero[1];
            default: w_blank = 1'b0;
        endcase
    end

    // Next anode/segment values: dark during dead time, else selected digit
    always_comb begin
        w_dead      = (r_presc < BLANK_LIM);
        w_anode_nxt = anode_sel(r_idx);
        w_seg_nxt   = w_blank ? SEG_OFF : w_dec;
        if (w_dead) begin
            w_anode_nxt = AN_OFF;
            w_seg_nxt   = SEG_OFF;
        end
    end

    // Output register: anode and segments update together, one cycle behind state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anode <= AN_OFF;
            r_seg   <= SEG_OFF;
        end else begin
            r_anode <= w_anode_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign anode   = r_anode;
    assign seg     = r_seg;
    assign bcd_err = r_err;

endmodule
